// File: rtl/control_suma_serie_if.sv
// Bus to the shared 4-bit ripple-carry adder. The sequencer is the master; the
// combinational adder is the slave.
interface control_suma_serie_if;
  logic [3:0] sum_a;
  logic [3:0] sum_b;
  logic       sum_cin;
  logic [3:0] sum_s;
  logic       sum_cout;

  modport master (
    output sum_a, sum_b, sum_cin,
    input  sum_s, sum_cout
  );

  modport slave (
    input  sum_a, sum_b, sum_cin,
    output sum_s, sum_cout
  );
endinterface

// File: rtl/control_suma_serie.sv
// Serial 16-bit add/subtract sequencer: reuses one external 4-bit adder over
// NIBBLES cycles, least-significant nibble first, then pulses fin.
module control_suma_serie #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   op,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
  control_suma_serie_if.master   sum,
  output logic                   listo,
  output logic                   ocupado,
  output logic                   fin,
  output logic [4*NIBBLES-1:0]   resultado,
  output logic                   cout,
  output logic                   ovf
);

  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {Reposo, Calculo, Fin} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, b_q, res_q;
  logic [IdxW-1:0] idx_q;
  logic            carry_q, cout_q, ovf_q;
  logic            last;

  assign last = (idx_q == IdxW'(NIBBLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= Reposo;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      Reposo:  if (start) state_d = Calculo;
      Calculo: if (last)  state_d = Fin;
      Fin:     state_d = Reposo;
      default: state_d = Reposo;
    endcase
  end

  always_comb begin
    listo       = (state_q == Reposo);
    ocupado     = (state_q == Calculo);
    fin         = (state_q == Fin);
    sum.sum_a   = 4'h0;
    sum.sum_b   = 4'h0;
    sum.sum_cin = 1'b0;
    if (state_q == Calculo) begin
      sum.sum_a   = a_q[4*idx_q +: 4];
      sum.sum_b   = b_q[4*idx_q +: 4];
      sum.sum_cin = carry_q;
    end
  end

  // Subtraction is a + ~b + 1: invert B on capture and seed the carry with 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        Reposo: begin
          if (start) begin
            a_q     <= a;
            b_q     <= op ? ~b : b;
            carry_q <= op ? 1'b1 : cin;
            res_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
          end
        end
        Calculo: begin
          res_q[4*idx_q +: 4] <= sum.sum_s;
          carry_q             <= sum.sum_cout;
          idx_q               <= idx_q + 1'b1;
          if (last) begin
            idx_q  <= '0;
            cout_q <= sum.sum_cout;
            ovf_q  <= (a_q[W-1] == b_q[W-1]) && (sum.sum_s[3] != a_q[W-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign resultado = res_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_control_suma_serie.sv
// Directed bench for control_suma_serie with a behavioural 4-bit adder on the
// adder bus.
module tb_control_suma_serie;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, op, cin;
  logic [15:0] a, b;
  logic        listo, ocupado, fin, cout, ovf;
  logic [15:0] resultado;

  int checks = 0;
  int errors = 0;

  control_suma_serie_if bus ();

  assign {bus.sum_cout, bus.sum_s} = bus.sum_a + bus.sum_b + bus.sum_cin;

  control_suma_serie #(.NIBBLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (bus.master),
    .listo     (listo),
    .ocupado   (ocupado),
    .fin       (fin),
    .resultado (resultado),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] exp_res;
    logic        exp_cout;
    logic        exp_ovf;
    logic [3:0]  exp_cin_seq;  // bit i = sum_cin during nibble i
    logic [3:0]  exp_b0;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int k);
    int         n;
    bit         got;
    logic [3:0] cin_seq;
    logic [3:0] a0, b0;
    string      t;
    t = $sformatf("v%0d", k);
    @(negedge clk);
    chk({t, "_listo_before"}, listo, 1);
    start = 1'b1; op = v.op; a = v.a; b = v.b; cin = v.cin;
    n = 0; got = 0; cin_seq = '0; a0 = '0; b0 = '0;
    while (!got && n < 10) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        // Scramble inputs: the operation in flight must not see them.
        start = 1'b0; op = ~v.op; a = ~v.a; b = 16'h5a5a; cin = ~v.cin;
        a0 = bus.sum_a; b0 = bus.sum_b;
        chk({t, "_ocupado"}, ocupado, 1);
      end
      if (n <= 4) cin_seq[n-1] = bus.sum_cin;
      if (fin) got = 1;
    end
    chk({t, "_fin_latency"}, n, 5);
    chk({t, "_resultado"}, resultado, v.exp_res);
    chk({t, "_cout"}, cout, v.exp_cout);
    chk({t, "_ovf"}, ovf, v.exp_ovf);
    chk({t, "_cin_seq"}, cin_seq, v.exp_cin_seq);
    chk({t, "_sum_b0"}, b0, v.exp_b0);
    chk({t, "_sum_a0"}, a0, v.a[3:0]);
    chk({t, "_bus_idle_fin"}, {bus.sum_a, bus.sum_b, bus.sum_cin}, 0);
    @(negedge clk);
    chk({t, "_listo_after"}, {listo, fin}, 2'b10);
    chk({t, "_res_held"}, resultado, v.exp_res);
  endtask

  initial begin
    int n, fins, fin_at;
    bit fin_seen;

    vecs[0] = '{1'b0, 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, 4'b1110, 4'hD};
    vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 4'b1110, 4'h1};
    vecs[2] = '{1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0, 4'b0001, 4'h8};
    vecs[3] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 4'b1110, 4'h1};
    vecs[4] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 4'b0001, 4'hE};
    vecs[5] = '{1'b0, 16'h0010, 16'h0020, 1'b1, 16'h0031, 1'b0, 1'b0, 4'b0001, 4'h0};
    vecs[6] = '{1'b1, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0, 4'b1111, 4'hB};

    rst_n = 1'b0; start = 1'b0; op = 1'b0; cin = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_flags", {listo, ocupado, fin, cout, ovf}, 5'b10000);
    chk("rst_resultado", resultado, 0);
    chk("rst_bus", {bus.sum_a, bus.sum_b, bus.sum_cin}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Start pulses during CALCULO and during FIN must be dropped.
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 16'h0001; b = 16'h0001; cin = 1'b0;
    fins = 0; fin_at = 0;
    for (n = 1; n <= 14; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 2) begin start = 1'b1; a = 16'hAAAA; end
      if (fin) begin
        fins++;
        if (fin_at == 0) fin_at = n;
        start = 1'b1; a = 16'hAAAA;
      end
    end
    start = 1'b0;
    chk("busy_fin_count", fins, 1);
    chk("busy_fin_latency", fin_at, 5);
    chk("busy_resultado", resultado, 16'h0002);
    chk("busy_listo", listo, 1);

    // Reset asserted for the second CALCULO edge aborts the operation.
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 16'h1111; b = 16'h2222; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_state", {listo, ocupado, fin}, 3'b100);
    chk("abort_resultado", resultado, 0);
    fin_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (fin) fin_seen = 1;
    end
    chk("abort_no_fin", fin_seen, 0);
    run_vec('{1'b0, 16'h0010, 16'h0020, 1'b0, 16'h0030, 1'b0, 1'b0, 4'b0000, 4'h0}, 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
